// File: rtl/nco_wave_meter_if.sv
// Result and sample bundle between the NCO side and the wave meter.
// The master drives samples, the select code and ready; the slave returns the measurements.
interface nco_wave_meter_if #(
   parameter int unsigned WAVE_WIDTH   = 8,
   parameter int unsigned SELECT_WIDTH = 3,
   parameter int unsigned CNT_WIDTH    = 12
);
   logic [WAVE_WIDTH-1:0]   wave_in;
   logic [SELECT_WIDTH-1:0] sel_in;
   logic                    meas_ready;
   logic                    meas_valid;
   logic [CNT_WIDTH-1:0]    meas_period;
   logic [WAVE_WIDTH-1:0]   meas_max;
   logic [WAVE_WIDTH-1:0]   meas_min;
   logic [SELECT_WIDTH-1:0] meas_sel;
   logic                    meas_timeout;
   logic [7:0]              drop_cnt;

   modport master (
      output wave_in, sel_in, meas_ready,
      input  meas_valid, meas_period, meas_max, meas_min, meas_sel, meas_timeout, drop_cnt
   );

   modport slave (
      input  wave_in, sel_in, meas_ready,
      output meas_valid, meas_period, meas_max, meas_min, meas_sel, meas_timeout, drop_cnt
   );
endinterface

// File: rtl/nco_wave_meter.sv
// Measures each NCO waveform cycle between rising midpoint crossings: period, max, min, select.
// Results pass through a one-deep pending stage into a valid/ready output register.
module nco_wave_meter #(
   parameter int unsigned WAVE_WIDTH   = 8,
   parameter int unsigned SELECT_WIDTH = 3,
   parameter int unsigned CNT_WIDTH    = 12,
   parameter int unsigned MAX_PERIOD   = 4095
) (
   input  logic             clk,
   input  logic             resetn,
   nco_wave_meter_if.slave  bus
);

   localparam logic [WAVE_WIDTH-1:0] MID     = {1'b1, {(WAVE_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX = CNT_WIDTH'(MAX_PERIOD);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [WAVE_WIDTH-1:0]   r_w1, r_w2;
   logic [1:0]              r_hist;
   logic [SELECT_WIDTH-1:0] r_sel_q;
   logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_nxt;
   logic [WAVE_WIDTH-1:0]   r_max, w_max_nxt;
   logic [WAVE_WIDTH-1:0]   r_min, w_min_nxt;

   logic                    w_emit;
   logic [CNT_WIDTH-1:0]    w_emit_period;
   logic                    w_emit_to;

   logic                    r_pend_vld;
   logic [CNT_WIDTH-1:0]    r_pend_period;
   logic [WAVE_WIDTH-1:0]   r_pend_max, r_pend_min;
   logic [SELECT_WIDTH-1:0] r_pend_sel;
   logic                    r_pend_to;

   logic                    r_out_vld;
   logic [CNT_WIDTH-1:0]    r_out_period;
   logic [WAVE_WIDTH-1:0]   r_out_max, r_out_min;
   logic [SELECT_WIDTH-1:0] r_out_sel;
   logic                    r_out_to;
   logic [7:0]              r_drop;

   logic                    w_cross;
   logic                    w_sel_chg;
   logic                    w_out_load;

   // Crossing is only trusted once both history registers hold real samples.
   assign w_cross    = (r_hist == 2'd2) && (r_w2 < MID) && (r_w1 >= MID);
   assign w_sel_chg  = (bus.sel_in != r_sel_q);
   assign w_out_load = !r_out_vld || bus.meas_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_max_nxt     = r_max;
      w_min_nxt     = r_min;
      w_emit        = 1'b0;
      w_emit_period = r_cnt;
      w_emit_to     = 1'b0;
      if (w_sel_chg) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cross) begin
                  w_cnt_nxt   = CNT_ONE;
                  w_max_nxt   = r_w1;
                  w_min_nxt   = r_w1;
                  w_state_nxt = ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (w_cross) begin
                  w_emit    = 1'b1;
                  w_cnt_nxt = CNT_ONE;
                  w_max_nxt = r_w1;
                  w_min_nxt = r_w1;
               end else if (r_cnt == CNT_MAX) begin
                  w_emit        = 1'b1;
                  w_emit_period = '0;
                  w_emit_to     = 1'b1;
                  w_state_nxt   = ST_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_ONE;
                  w_max_nxt = (r_w1 > r_max) ? r_w1 : r_max;
                  w_min_nxt = (r_w1 < r_min) ? r_w1 : r_min;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_w1          <= '0;
         r_w2          <= '0;
         r_hist        <= '0;
         r_sel_q       <= '0;
         r_cnt         <= '0;
         r_max         <= '0;
         r_min         <= '0;
         r_pend_vld    <= 1'b0;
         r_pend_period <= '0;
         r_pend_max    <= '0;
         r_pend_min    <= '0;
         r_pend_sel    <= '0;
         r_pend_to     <= 1'b0;
         r_out_vld     <= 1'b0;
         r_out_period  <= '0;
         r_out_max     <= '0;
         r_out_min     <= '0;
         r_out_sel     <= '0;
         r_out_to      <= 1'b0;
         r_drop        <= '0;
      end else begin
         r_w1    <= bus.wave_in;
         r_w2    <= r_w1;
         r_sel_q <= bus.sel_in;
         if (w_sel_chg)
            r_hist <= '0;
         else if (r_hist != 2'd2)
            r_hist <= r_hist + 2'd1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_max   <= w_max_nxt;
         r_min   <= w_min_nxt;

         r_pend_vld <= w_emit;
         if (w_emit) begin
            r_pend_period <= w_emit_period;
            r_pend_max    <= r_max;
            r_pend_min    <= r_min;
            r_pend_sel    <= r_sel_q;
            r_pend_to     <= w_emit_to;
         end

         // Load-on-accept keeps one result per clock; a result arriving while held is dropped.
         if (w_out_load) begin
            r_out_vld <= r_pend_vld;
            if (r_pend_vld) begin
               r_out_period <= r_pend_period;
               r_out_max    <= r_pend_max;
               r_out_min    <= r_pend_min;
               r_out_sel    <= r_pend_sel;
               r_out_to     <= r_pend_to;
            end
         end else if (r_pend_vld && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

   assign bus.meas_valid   = r_out_vld;
   assign bus.meas_period  = r_out_period;
   assign bus.meas_max     = r_out_max;
   assign bus.meas_min     = r_out_min;
   assign bus.meas_sel     = r_out_sel;
   assign bus.meas_timeout = r_out_to;
   assign bus.drop_cnt     = r_drop;

endmodule
